// File: rtl/hwag_regbank_pkg.sv
// Shared types and helpers for the HWAG register bank.
// Decides each register's access type from the RO and W1C masks.
package hwag_regbank_pkg;

  typedef enum logic [1:0] {REG_RW, REG_RO, REG_W1C} reg_access_t;

  // Widest mask access_of accepts; callers zero-extend their REG_N-bit masks.
  localparam int MAX_REG_N = 4096;

  // RO takes priority when a register is flagged in both masks.
  function automatic reg_access_t access_of(input int i,
                                            input logic [MAX_REG_N-1:0] ro_mask,
                                            input logic [MAX_REG_N-1:0] w1c_mask);
    if (ro_mask[i])
      return REG_RO;
    else if (w1c_mask[i])
      return REG_W1C;
    else
      return REG_RW;
  endfunction

endpackage

// File: rtl/hwag_reg_cell.sv
// One register of the HWAG bank: RW storage, RO passthrough of hw_in,
// or sticky W1C event bits (hardware set wins over a bus clear).
module hwag_reg_cell
  import hwag_regbank_pkg::*;
#(
  parameter int          DATA_W = 16,
  parameter reg_access_t ACCESS = REG_RW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] wmask,
  input  logic [DATA_W-1:0] hw_in,
  output logic [DATA_W-1:0] value
);

  if (ACCESS == REG_RO) begin : g_ro
    logic unused_ro;
    assign unused_ro = &{1'b0, clk, rst, we, wdata, wmask};
    assign value = hw_in;
  end else if (ACCESS == REG_W1C) begin : g_w1c
    logic [DATA_W-1:0] value_reg;
    logic [DATA_W-1:0] clr_bits;
    assign clr_bits = we ? (wdata & wmask) : '0;
    always_ff @(posedge clk) begin
      if (rst)
        value_reg <= '0;
      else
        value_reg <= (value_reg & ~clr_bits) | hw_in;
    end
    assign value = value_reg;
  end else begin : g_rw
    logic [DATA_W-1:0] value_reg;
    logic unused_rw;
    assign unused_rw = &{1'b0, hw_in};
    always_ff @(posedge clk) begin
      if (rst)
        value_reg <= '0;
      else if (we)
        value_reg <= (value_reg & ~wmask) | (wdata & wmask);
    end
    assign value = value_reg;
  end

endmodule

// File: rtl/hwag_regbank.sv
// Host-accessible HWAG register bank: address decode, error detection, registered read.
// Optional byte strobes (bus_wstrb) are enabled by defining HWAG_REGBANK_WSTRB_EN.
module hwag_regbank
  import hwag_regbank_pkg::*;
#(
  parameter int               DATA_W   = 16,
  parameter int               ADDR_W   = 8,
  parameter int               REG_N    = 64,
  parameter logic [REG_N-1:0] RO_MASK  = '0,
  parameter logic [REG_N-1:0] W1C_MASK = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bus_we,
  input  logic                    bus_re,
  input  logic [ADDR_W-1:0]       bus_addr,
  input  logic [DATA_W-1:0]       bus_wdata,
`ifdef HWAG_REGBANK_WSTRB_EN
  input  logic [DATA_W/8-1:0]     bus_wstrb,
`endif
  output logic [DATA_W-1:0]       bus_rdata,
  output logic                    bus_rvalid,
  output logic                    bus_err,
  input  logic [REG_N*DATA_W-1:0] hw_in,
  output logic [REG_N*DATA_W-1:0] reg_out,
  output logic [REG_N-1:0]        reg_wpulse
);

  localparam logic [MAX_REG_N-1:0] RO_EXT  = MAX_REG_N'(RO_MASK);
  localparam logic [MAX_REG_N-1:0] W1C_EXT = MAX_REG_N'(W1C_MASK);

  logic [REG_N-1:0]  sel;
  logic [REG_N-1:0]  is_ro;
  logic [REG_N-1:0]  wr_hit;
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] rd_mux;
  logic              addr_hit;
  logic              ro_write;

  logic [DATA_W-1:0] rdata_reg;
  logic              rvalid_reg;
  logic              err_reg;
  logic [REG_N-1:0]  wpulse_reg;

`ifdef HWAG_REGBANK_WSTRB_EN
  for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_wmask
    assign wmask[gi*8 +: 8] = {8{bus_wstrb[gi]}};
  end
`else
  assign wmask = '1;
`endif

  // Full-width compare per register, so addresses >= REG_N never alias.
  for (genvar gi = 0; gi < REG_N; gi++) begin : g_reg
    localparam reg_access_t ACC = access_of(gi, RO_EXT, W1C_EXT);

    assign sel[gi]    = (bus_addr == ADDR_W'(gi));
    assign is_ro[gi]  = (ACC == REG_RO);
    assign wr_hit[gi] = bus_we & sel[gi] & ~is_ro[gi];

    hwag_reg_cell #(
      .DATA_W (DATA_W),
      .ACCESS (ACC)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_hit[gi]),
      .wdata (bus_wdata),
      .wmask (wmask),
      .hw_in (hw_in[gi*DATA_W +: DATA_W]),
      .value (reg_out[gi*DATA_W +: DATA_W])
    );
  end

  assign addr_hit = |sel;
  assign ro_write = bus_we & |(sel & is_ro);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < REG_N; i++) begin
      if (sel[i])
        rd_mux = rd_mux | reg_out[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
      wpulse_reg <= '0;
    end else begin
      rvalid_reg <= bus_re;
      if (bus_re)
        rdata_reg <= rd_mux;
      err_reg    <= ((bus_we | bus_re) & ~addr_hit) | ro_write;
      wpulse_reg <= wr_hit;
    end
  end

  assign bus_rdata  = rdata_reg;
  assign bus_rvalid = rvalid_reg;
  assign bus_err    = err_reg;
  assign reg_wpulse = wpulse_reg;

endmodule

// File: tb/tb_hwag_regbank.sv
// Directed self-checking bench for hwag_regbank (reg 2 RO, reg 3 W1C, rest RW).
// Byte-strobe checks run only when HWAG_REGBANK_WSTRB_EN is defined.
module tb_hwag_regbank;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int REG_N  = 64;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    bus_we;
  logic                    bus_re;
  logic [ADDR_W-1:0]       bus_addr;
  logic [DATA_W-1:0]       bus_wdata;
`ifdef HWAG_REGBANK_WSTRB_EN
  logic [DATA_W/8-1:0]     bus_wstrb;
`endif
  logic [DATA_W-1:0]       bus_rdata;
  logic                    bus_rvalid;
  logic                    bus_err;
  logic [REG_N*DATA_W-1:0] hw_in;
  logic [REG_N*DATA_W-1:0] reg_out;
  logic [REG_N-1:0]        reg_wpulse;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hwag_regbank #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .REG_N    (REG_N),
    .RO_MASK  (64'h0000_0000_0000_0004),
    .W1C_MASK (64'h0000_0000_0000_0008)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
`ifdef HWAG_REGBANK_WSTRB_EN
    .bus_wstrb  (bus_wstrb),
`endif
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .bus_err    (bus_err),
    .hw_in      (hw_in),
    .reg_out    (reg_out),
    .reg_wpulse (reg_wpulse)
  );

  function automatic logic [DATA_W-1:0] reg_val(input int i);
    return reg_out[i*DATA_W +: DATA_W];
  endfunction

  task automatic idle();
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
`ifdef HWAG_REGBANK_WSTRB_EN
    bus_wstrb = '1;
`endif
  endtask

  // Apply current inputs across one rising edge, then settle for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    hw_in = '0;
    step();
    step();
    check("reset_rvalid", 64'(bus_rvalid), 64'h0);
    check("reset_err", 64'(bus_err), 64'h0);
    check("reset_rdata", 64'(bus_rdata), 64'h0);
    check("reset_wpulse", 64'(reg_wpulse), 64'h0);
    check("reset_reg5", 64'(reg_val(5)), 64'h0);
    rst = 1'b0;
    step();
    for (int a = 0; a < REG_N; a++) begin
      bus_re   = 1'b1;
      bus_addr = ADDR_W'(a);
      step();
      bus_re = 1'b0;
      check($sformatf("reset_read_rdata_%0d", a), 64'(bus_rdata), 64'h0);
      check($sformatf("reset_read_rvalid_%0d", a), 64'(bus_rvalid), 64'h1);
      check($sformatf("reset_read_err_%0d", a), 64'(bus_err), 64'h0);
    end
    step();
    check("rvalid_drops", 64'(bus_rvalid), 64'h0);
    $display("[TB] reset and read-all done");
  endtask

  task automatic test_rw();
    bus_we = 1'b1; bus_addr = 8'd5; bus_wdata = 16'hA5C3;
    step();
    idle();
    check("rw_reg5", 64'(reg_val(5)), 64'hA5C3);
    check("rw_wpulse", 64'(reg_wpulse), 64'h20);
    check("rw_err", 64'(bus_err), 64'h0);
    step();
    check("rw_wpulse_single", 64'(reg_wpulse), 64'h0);
    bus_re = 1'b1; bus_addr = 8'd5;
    step();
    idle();
    check("rw_readback", 64'(bus_rdata), 64'hA5C3);
    check("rw_readback_valid", 64'(bus_rvalid), 64'h1);
    step();
    check("rdata_hold", 64'(bus_rdata), 64'hA5C3);
    check("rdata_hold_valid", 64'(bus_rvalid), 64'h0);
    $display("[TB] write/read RW reg 5 done");
  endtask

  task automatic test_ro();
    hw_in[2*DATA_W +: DATA_W] = 16'h1234;
    #1;
    check("ro_follow", 64'(reg_val(2)), 64'h1234);
    bus_we = 1'b1; bus_addr = 8'd2; bus_wdata = 16'hFFFF;
    step();
    idle();
    check("ro_write_err", 64'(bus_err), 64'h1);
    check("ro_write_nopulse", 64'(reg_wpulse), 64'h0);
    check("ro_unchanged", 64'(reg_val(2)), 64'h1234);
    bus_re = 1'b1; bus_addr = 8'd2;
    step();
    idle();
    check("ro_read", 64'(bus_rdata), 64'h1234);
    check("ro_read_err", 64'(bus_err), 64'h0);
    $display("[TB] RO reg 2 done");
  endtask

  task automatic test_w1c();
    hw_in[3*DATA_W +: DATA_W] = 16'h0011;
    step();
    hw_in[3*DATA_W +: DATA_W] = 16'h0000;
    check("w1c_set", 64'(reg_val(3)), 64'h0011);
    step();
    check("w1c_sticky", 64'(reg_val(3)), 64'h0011);
    bus_we = 1'b1; bus_addr = 8'd3; bus_wdata = 16'h0001;
    hw_in[3*DATA_W +: DATA_W] = 16'h0001;
    step();
    idle();
    hw_in[3*DATA_W +: DATA_W] = 16'h0000;
    check("w1c_hw_wins", 64'(reg_val(3)), 64'h0011);
    check("w1c_wpulse", 64'(reg_wpulse), 64'h8);
    bus_we = 1'b1; bus_addr = 8'd3; bus_wdata = 16'h0011;
    step();
    idle();
    check("w1c_clear", 64'(reg_val(3)), 64'h0000);
    hw_in[3*DATA_W +: DATA_W] = 16'h0100;
    step();
    hw_in[3*DATA_W +: DATA_W] = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      bus_re = 1'b1; bus_addr = 8'd3;
      step();
      idle();
      check($sformatf("w1c_read_%0d", k), 64'(bus_rdata), 64'h0100);
    end
    check("w1c_read_noside", 64'(reg_val(3)), 64'h0100);
    $display("[TB] W1C reg 3 done");
  endtask

  task automatic test_rdwr_unmapped();
    bus_we = 1'b1; bus_addr = 8'd7; bus_wdata = 16'h0001;
    step();
    bus_re = 1'b1; bus_wdata = 16'h0002;
    step();
    idle();
    check("rdwr_old", 64'(bus_rdata), 64'h0001);
    check("rdwr_new", 64'(reg_val(7)), 64'h0002);
    check("rdwr_pulse", 64'(reg_wpulse), 64'h80);
    bus_re = 1'b1; bus_addr = 8'd64;
    step();
    idle();
    check("unmapped_rdata", 64'(bus_rdata), 64'h0);
    check("unmapped_rvalid", 64'(bus_rvalid), 64'h1);
    check("unmapped_err", 64'(bus_err), 64'h1);
    step();
    check("err_single", 64'(bus_err), 64'h0);
    bus_we = 1'b1; bus_addr = 8'd200; bus_wdata = 16'hBEEF;
    step();
    idle();
    check("unmapped_wr_err", 64'(bus_err), 64'h1);
    check("unmapped_wr_nopulse", 64'(reg_wpulse), 64'h0);
    check("no_alias_reg8", 64'(reg_val(200 % REG_N)), 64'h0);
    $display("[TB] read+write and unmapped done");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      bus_we = 1'b1; bus_addr = ADDR_W'(10 + k); bus_wdata = 16'(16'h1000 + k);
      step();
      check($sformatf("b2b_wpulse_%0d", k), 64'(reg_wpulse), 64'(64'h1 << (10 + k)));
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      bus_re = 1'b1; bus_addr = ADDR_W'(10 + k);
      step();
      check($sformatf("b2b_read_%0d", k), 64'(bus_rdata), 64'(16'h1000 + k));
      check($sformatf("b2b_valid_%0d", k), 64'(bus_rvalid), 64'h1);
    end
    idle();
    $display("[TB] back-to-back done");
  endtask

`ifdef HWAG_REGBANK_WSTRB_EN
  task automatic test_wstrb();
    bus_we = 1'b1; bus_addr = 8'd5; bus_wdata = 16'hA5C3;
    step();
    bus_wdata = 16'h1234; bus_wstrb = 2'b01;
    step();
    idle();
    check("wstrb_low", 64'(reg_val(5)), 64'hA534);
    bus_we = 1'b1; bus_addr = 8'd5; bus_wdata = 16'hFFFF; bus_wstrb = 2'b00;
    step();
    idle();
    check("wstrb_none", 64'(reg_val(5)), 64'hA534);
    check("wstrb_none_pulse", 64'(reg_wpulse), 64'h20);
    $display("[TB] write strobes done");
  endtask
`endif

  task automatic test_reset_mid();
    bus_we = 1'b1; bus_addr = 8'd6; bus_wdata = 16'h5555;
    step();
    bus_addr = 8'd9; bus_wdata = 16'h7777; bus_re = 1'b1;
    hw_in[3*DATA_W +: DATA_W] = 16'h0F00;
    rst = 1'b1;
    step();
    idle();
    hw_in[3*DATA_W +: DATA_W] = 16'h0000;
    check("rstmid_reg6", 64'(reg_val(6)), 64'h0);
    check("rstmid_reg9", 64'(reg_val(9)), 64'h0);
    check("rstmid_reg5", 64'(reg_val(5)), 64'h0);
    check("rstmid_w1c", 64'(reg_val(3)), 64'h0);
    check("rstmid_rvalid", 64'(bus_rvalid), 64'h0);
    check("rstmid_wpulse", 64'(reg_wpulse), 64'h0);
    check("rstmid_ro", 64'(reg_val(2)), 64'h1234);
    rst = 1'b0;
    step();
    $display("[TB] reset mid-burst done");
  endtask

  initial begin
    test_reset();
    test_rw();
    test_ro();
    test_w1c();
    test_rdwr_unmapped();
    test_back_to_back();
`ifdef HWAG_REGBANK_WSTRB_EN
    test_wstrb();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
